// File: rtl/iopad_ccff_loader_pkg.sv
// Shared types and constants for the io-column ccff programming controller.
// The CRC helper is only used when CCFF_READBACK_EN is defined.
package iopad_ccff_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_VERIFY = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // One serial step of CRC-16/CCITT, MSB-first register update.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/iopad_ccff_loader_crc16.sv
// Serial CRC-16/CCITT accumulator (init 0xFFFF); clr has priority over en.
module ccff_crc16
    import iopad_ccff_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    logic [15:0] r_crc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc <= CRC_INIT;
        end else if (clr) begin
            r_crc <= CRC_INIT;
        end else if (en) begin
            r_crc <= crc16_step(r_crc, din);
        end
    end

    assign crc = r_crc;

endmodule

// File: rtl/iopad_ccff_loader.sv
// Loads CHAIN_LEN bits LSB-first from a word stream into the io-column ccff chain.
// Define CCFF_READBACK_EN to add a non-destructive recirculating CRC check after the load.
module iopad_ccff_loader
    import iopad_ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 32
) (
    input  logic              prog_clock,
    input  logic              global_reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              config_enable,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              error,
    output state_e            o_dbg_state
);

    localparam int REM_W = $clog2(CHAIN_LEN + 1);
    localparam int BIT_W = $clog2(WORD_W + 1);

    // word_ready/word_valid: a word transfers on the rising edge where both are high;
    // word_ready is only offered in FETCH and drops the cycle after the transfer.
    state_e            r_state;
    logic [REM_W-1:0]  r_rem;
    logic [BIT_W-1:0]  r_bits;
    logic [WORD_W-1:0] r_sreg;
    logic              r_ready;
    logic              r_cfg_en;
    logic              r_busy;
    logic              r_done;

    logic [WORD_W-1:0] w_sreg_nxt;
    logic [REM_W-1:0]  w_rem_dec;
    logic [BIT_W-1:0]  w_bits_dec;
    logic [BIT_W-1:0]  w_first_bits;
    logic              w_rem_last;
    logic              w_word_last;

    assign w_sreg_nxt   = r_sreg >> 1;
    assign w_rem_dec    = (r_rem != '0) ? r_rem - REM_W'(1) : '0;
    assign w_bits_dec   = (r_bits != '0) ? r_bits - BIT_W'(1) : '0;
    assign w_rem_last   = (r_rem <= REM_W'(1));
    assign w_word_last  = (r_bits <= BIT_W'(1));
    assign w_first_bits = (int'(r_rem) >= WORD_W) ? BIT_W'(WORD_W) : BIT_W'(r_rem);

`ifdef CCFF_READBACK_EN
    logic        r_verify;
    logic        r_error;
    logic        w_crc_clr;
    logic [15:0] w_crc_head;
    logic [15:0] w_crc_tail;
    logic [15:0] w_crc_tail_nxt;

    assign w_crc_clr = (r_state == ST_IDLE) && start && !abort;

    ccff_crc16 u_crc_head (
        .clk   (prog_clock),
        .rst_n (global_reset_n),
        .clr   (w_crc_clr),
        .en    (r_state == ST_SHIFT),
        .din   (r_sreg[0]),
        .crc   (w_crc_head)
    );

    ccff_crc16 u_crc_tail (
        .clk   (prog_clock),
        .rst_n (global_reset_n),
        .clr   (w_crc_clr),
        .en    (r_state == ST_VERIFY),
        .din   (ccff_tail),
        .crc   (w_crc_tail)
    );

    // The final tail bit is folded in here so error can rise together with done.
    assign w_crc_tail_nxt = crc16_step(w_crc_tail, ccff_tail);
    // Recirculation must be a straight wire: a flop in the loop would rotate the chain.
    assign ccff_head      = r_verify ? ccff_tail : r_sreg[0];
    assign error          = r_error;
`else
    logic w_unused_tail;
    assign w_unused_tail = ccff_tail;
    assign ccff_head     = r_sreg[0];
    assign error         = 1'b0;
`endif

    always_ff @(posedge prog_clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            r_state  <= ST_IDLE;
            r_rem    <= '0;
            r_bits   <= '0;
            r_sreg   <= '0;
            r_ready  <= 1'b0;
            r_cfg_en <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef CCFF_READBACK_EN
            r_verify <= 1'b0;
            r_error  <= 1'b0;
`endif
        end else if (abort) begin
            r_state  <= ST_IDLE;
            r_sreg   <= '0;
            r_ready  <= 1'b0;
            r_cfg_en <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef CCFF_READBACK_EN
            r_verify <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_FETCH;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b1;
                        r_rem   <= REM_W'(CHAIN_LEN);
                        r_bits  <= '0;
`ifdef CCFF_READBACK_EN
                        r_error <= 1'b0;
`endif
                    end
                end
                ST_FETCH: begin
                    if (word_valid) begin
                        r_state  <= ST_SHIFT;
                        r_sreg   <= word_data;
                        r_bits   <= w_first_bits;
                        r_ready  <= 1'b0;
                        r_cfg_en <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    r_sreg <= w_sreg_nxt;
                    r_rem  <= w_rem_dec;
                    r_bits <= w_bits_dec;
                    if (w_rem_last) begin
                        // Leftover upper bits of the last word are dropped here.
                        r_sreg <= '0;
`ifdef CCFF_READBACK_EN
                        r_state  <= ST_VERIFY;
                        r_verify <= 1'b1;
                        r_rem    <= REM_W'(CHAIN_LEN);
`else
                        r_state  <= ST_DONE;
                        r_cfg_en <= 1'b0;
                        r_done   <= 1'b1;
`endif
                    end else if (w_word_last) begin
                        r_state  <= ST_FETCH;
                        r_sreg   <= '0;
                        r_cfg_en <= 1'b0;
                        r_ready  <= 1'b1;
                    end
                end
`ifdef CCFF_READBACK_EN
                ST_VERIFY: begin
                    r_rem <= w_rem_dec;
                    if (w_rem_last) begin
                        r_state  <= ST_DONE;
                        r_verify <= 1'b0;
                        r_cfg_en <= 1'b0;
                        r_done   <= 1'b1;
                        r_error  <= (w_crc_head != w_crc_tail_nxt);
                    end
                end
`endif
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign word_ready    = r_ready;
    assign config_enable = r_cfg_en;
    assign busy          = r_busy;
    assign done          = r_done;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_iopad_ccff_loader.sv
// Bench for iopad_ccff_loader: bit-stream scoreboard, ideal chain model and directed loads.
module tb_iopad_ccff_loader;
  import iopad_ccff_loader_pkg::*;

  localparam int CHAIN_LEN = 40;
  localparam int WORD_W    = 32;
`ifdef CCFF_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif
  localparam int VCYC = READBACK ? CHAIN_LEN : 0;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              word_valid = 1'b0;
  logic [WORD_W-1:0] word_data = '0;
  logic              word_ready, config_enable, ccff_head, ccff_tail, busy, done, error;
  state_e            dbg_state;

  logic [CHAIN_LEN-1:0] chain = '0;
  logic                 tail_flip = 1'b0;
  int                   cyc = 0;
  int                   n_vec = 0;
  int                   n_bad = 0;
  logic                 chk_on = 1'b0;

  iopad_ccff_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
    .prog_clock     (clk),
    .global_reset_n (rst_n),
    .start          (start),
    .abort          (abort),
    .word_data      (word_data),
    .word_valid     (word_valid),
    .word_ready     (word_ready),
    .config_enable  (config_enable),
    .ccff_head      (ccff_head),
    .ccff_tail      (ccff_tail),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .o_dbg_state    (dbg_state)
  );

  // clock / cycle counter / ideal chain (head enters at the top, tail is bit 0)
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (config_enable) chain <= {ccff_head, chain[CHAIN_LEN-1:1]};
  assign ccff_tail = chain[0] ^ tail_flip;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // scoreboard: expected serial bits, stream record, phase bookkeeping
  logic [0:0] exp_q[$];
  logic [0:0] stream[$];
  int  bits_left = 0;
  int  vleft = 0;
  int  done_due = -1;
  bit  model_busy = 1'b0;
  bit  model_error = 1'b0;
  bit  vbad = 1'b0;
  int  pops = 0;
  int  first_pop = -1;
  int  last_pop = -1;

  always @(negedge clk) begin
    logic       exp_rdy;
    logic [0:0] b;
    int         n;
    if (!rst_n) begin
      exp_q.delete();
      stream.delete();
      bits_left   = 0;
      vleft       = 0;
      done_due    = -1;
      model_busy  = 1'b0;
      model_error = 1'b0;
    end else if (chk_on) begin
      exp_rdy = model_busy && (exp_q.size() == 0) && (bits_left > 0) && (vleft == 0);
      chk("busy", busy, model_busy);
      chk("done", done, cyc == done_due);
      chk("error", error, model_error);
      chk("word_ready", word_ready, exp_rdy);
      chk("config_enable", config_enable, (exp_q.size() != 0) || (vleft != 0));
      if (exp_q.size() != 0) begin
        b = exp_q.pop_front();
        chk("ccff_head", ccff_head, b);
        pops++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        if (exp_q.size() == 0 && bits_left == 0) begin
          if (READBACK) vleft = CHAIN_LEN;
          else done_due = cyc + 1;
        end
      end else if (vleft != 0) begin
        chk("recirculate", ccff_head, ccff_tail);
        if (ccff_tail !== stream[CHAIN_LEN - vleft]) vbad = 1'b1;
        vleft--;
        if (vleft == 0) begin
          done_due    = cyc + 1;
          model_error = vbad;
        end
      end
      // predict the coming edge
      if (abort) begin
        exp_q.delete();
        bits_left  = 0;
        vleft      = 0;
        done_due   = -1;
        model_busy = 1'b0;
      end else begin
        if (cyc == done_due) model_busy = 1'b0;
        else if (start && !model_busy) begin
          model_busy  = 1'b1;
          model_error = 1'b0;
          bits_left   = CHAIN_LEN;
          vbad        = 1'b0;
          pops        = 0;
          first_pop   = -1;
          last_pop    = -1;
          exp_q.delete();
          stream.delete();
        end else if (word_valid && exp_rdy) begin
          n = (bits_left < WORD_W) ? bits_left : WORD_W;
          for (int i = 0; i < n; i++) begin
            exp_q.push_back(word_data[i]);
            stream.push_back(word_data[i]);
          end
          bits_left -= n;
        end
      end
    end
  end

  // driver tasks
  task automatic start_pulse(output int s);
    @(posedge clk); #1;
    start = 1'b1;
    s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [WORD_W-1:0] d, input int gap);
    bit got;
    word_data = d;
    if (gap > 0) begin
      word_valid = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 200 && !got; k++) begin
        @(negedge clk);
        got = word_ready;
      end
      if (!got) chk("fetch_timeout", 0, 1);
      repeat (gap) begin @(posedge clk); #1; end
    end
    word_valid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      got = word_ready;
    end
    if (!got) chk("handshake_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_done(output int dc);
    bit got;
    got = 1'b0;
    dc  = -1;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        dc  = cyc;
      end
    end
    if (!got) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int s;
    int dc;
    // reset values
    #12;
    chk("rst_word_ready", word_ready, 0);
    chk("rst_config_enable", config_enable, 0);
    chk("rst_ccff_head", ccff_head, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    chk_on = 1'b1;

    // two words, valid held
    start_pulse(s);
    send_word(32'hA5A5A5A5, 0);
    send_word(32'h000000C3, 0);
    word_valid = 1'b0;
    wait_done(dc);
    chk("t1_latency", dc - s, 43 + VCYC);
    chk("t1_bits", pops, 40);
    chk("t1_gap", last_pop - first_pop + 1 - pops, 1);
    chk("t1_chain", 64'(chain), 64'hC3A5A5A5A5);

    // 5-cycle word gap, junk upper bits in last word, start pulsed while busy
    start_pulse(s);
    send_word(32'h5A5A5A5A, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    send_word(32'hDEAD003C, 5);
    word_valid = 1'b0;
    wait_done(dc);
    chk("t2_latency", dc - s, 48 + VCYC);
    chk("t2_bits", pops, 40);
    chk("t2_gap", last_pop - first_pop + 1 - pops, 6);
    chk("t2_chain", 64'(chain), 64'h3C5A5A5A5A);

    // abort on the 10th shift cycle, then a full reload
    start_pulse(s);
    word_data  = 32'h87654321;
    word_valid = 1'b1;
    send_word(32'h87654321, 0);
    repeat (9) begin @(posedge clk); #1; end
    abort      = 1'b1;
    word_valid = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_config_enable", config_enable, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_state", dbg_state, ST_IDLE);
    chk("abort_bits", pops, 10);
    repeat (3) begin @(posedge clk); #1; end
    start_pulse(s);
    send_word(32'h12345678, 0);
    send_word(32'h0000009E, 0);
    word_valid = 1'b0;
    wait_done(dc);
    chk("t3_latency", dc - s, 43 + VCYC);
    chk("t3_chain", 64'(chain), 64'h9E12345678);

`ifdef CCFF_READBACK_EN
    // corrupt one recirculated bit mid-verify
    start_pulse(s);
    send_word(32'hA5A5A5A5, 0);
    send_word(32'h000000C3, 0);
    word_valid = 1'b0;
    for (int k = 0; k < 300 && cyc != s + 60; k++) begin @(posedge clk); #1; end
    tail_flip = 1'b1;
    @(posedge clk); #1;
    tail_flip = 1'b0;
    wait_done(dc);
    chk("rb_latency", dc - s, 83);
    chk("rb_error", error, 1);
`endif

    // asynchronous reset mid-shift
    start_pulse(s);
    send_word(32'hFFFFFFFF, 0);
    repeat (3) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    word_valid = 1'b0;
    #1;
    chk("mid_rst_config_enable", config_enable, 0);
    chk("mid_rst_ccff_head", ccff_head, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_word_ready", word_ready, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_error", error, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_state", dbg_state, ST_IDLE);
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
